// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with NRD combinational ALU read ports, one memory
//   load/store port, one ALU write port, optional write-to-read bypass and a
//   per-register pending-load scoreboard. Register 0 holds the IR: only the
//   memory port may write it, and ALU ports always read it as zero.
//
// Ports
//   clk          clock, all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   mem_idx      memory port register index (load and store)
//   mem_load     load data
//   mem_load_en  write mem_load into regs[mem_idx], completes a pending load
//   mem_store    regs[mem_idx], combinational, never bypassed
//   ld_issue     a memory load to ld_idx has been issued
//   ld_idx       destination of the issued load
//   rs_i         ALU source indices, port k = rs_i[k*IDXW +: IDXW]
//   rs           ALU source data, port k = rs[k*WIDTH +: WIDTH]
//   rs_busy      source k has a load pending that is not completing now
//   rd_i         ALU destination index, 0 = no write
//   rd           ALU result
//   busy         registered scoreboard vector
//   ld_overlap   registered pulse: a load was issued to an already-busy reg
module regfile_scoreboard #(
    parameter int              WIDTH     = 16,
    parameter int              DEPTH     = 16,
    parameter int              NRD       = 2,
    parameter int              BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             IDXW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDXW-1:0]       mem_idx,
    input  logic [WIDTH-1:0]      mem_load,
    input  logic                  mem_load_en,
    output logic [WIDTH-1:0]      mem_store,
    input  logic                  ld_issue,
    input  logic [IDXW-1:0]       ld_idx,
    input  logic [NRD*IDXW-1:0]   rs_i,
    output logic [NRD*WIDTH-1:0]  rs,
    output logic [NRD-1:0]        rs_busy,
    input  logic [IDXW-1:0]       rd_i,
    input  logic [WIDTH-1:0]      rd,
    output logic [DEPTH-1:0]      busy,
    output logic                  ld_overlap
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             alu_we;
    logic             ld_set;
    logic [DEPTH-1:0] busy_next;
    logic             overlap_next;

    // Index 0 on the ALU port means "no write", which also protects the IR.
    assign alu_we = (rd_i != '0);
    assign ld_set = ld_issue && (ld_idx != '0);

    // The ALU assignment comes second so it overrides the memory write when
    // both ports target the same register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (mem_load_en) begin
                regs[mem_idx] <= mem_load;
            end
            if (alu_we) begin
                regs[rd_i] <= rd;
            end
        end
    end

    // Set is applied after clear so a completing load and a fresh issue to the
    // same register keep it busy (back-to-back loads).
    always_comb begin
        busy_next = busy;
        if (mem_load_en) begin
            busy_next[mem_idx] = 1'b0;
        end
        if (ld_set) begin
            busy_next[ld_idx] = 1'b1;
        end
    end

    // An issue to a register whose earlier load completes on this very edge
    // is a normal back-to-back load, not an overlap.
    assign overlap_next = ld_set && busy[ld_idx] &&
                          !(mem_load_en && (mem_idx == ld_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            ld_overlap <= 1'b0;
        end else begin
            busy       <= busy_next;
            ld_overlap <= overlap_next;
        end
    end

    assign mem_store = regs[mem_idx];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IDXW-1:0] idx;
        logic            alu_hit;
        logic            mem_hit;

        assign idx     = rs_i[k*IDXW +: IDXW];
        assign alu_hit = (BYPASS != 0) && alu_we && (rd_i == idx);
        assign mem_hit = mem_load_en && (mem_idx == idx);

        assign rs[k*WIDTH +: WIDTH] = (idx == '0)                    ? '0       :
                                      alu_hit                        ? rd       :
                                      ((BYPASS != 0) && mem_hit)     ? mem_load :
                                                                       regs[idx];

        // With bypass, a load completing this cycle already delivers its data,
        // so the source no longer needs to stall.
        assign rs_busy[k] = (idx != '0) && busy[idx] &&
                            !((BYPASS != 0) && mem_hit);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (WIDTH 16, DEPTH 16, NRD 2, BYPASS 1)
    logic [3:0]  mem_idx, ld_idx, rd_i;
    logic [15:0] mem_load, rd, mem_store, busy;
    logic        mem_load_en, ld_issue, ld_overlap;
    logic [7:0]  rs_i;
    logic [31:0] rs;
    logic [1:0]  rs_busy;

    // Instance B: WIDTH 32, NRD 3, BYPASS 0
    logic [3:0]  b_mem_idx, b_ld_idx, b_rd_i;
    logic [31:0] b_mem_load, b_rd, b_mem_store;
    logic [15:0] b_busy;
    logic        b_mem_load_en, b_ld_issue, b_ld_overlap;
    logic [11:0] b_rs_i;
    logic [95:0] b_rs;
    logic [2:0]  b_rs_busy;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .mem_idx(mem_idx), .mem_load(mem_load), .mem_load_en(mem_load_en),
        .mem_store(mem_store), .ld_issue(ld_issue), .ld_idx(ld_idx),
        .rs_i(rs_i), .rs(rs), .rs_busy(rs_busy), .rd_i(rd_i), .rd(rd),
        .busy(busy), .ld_overlap(ld_overlap)
    );

    regfile_scoreboard #(.WIDTH(32), .NRD(3), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .mem_idx(b_mem_idx), .mem_load(b_mem_load), .mem_load_en(b_mem_load_en),
        .mem_store(b_mem_store), .ld_issue(b_ld_issue), .ld_idx(b_ld_idx),
        .rs_i(b_rs_i), .rs(b_rs), .rs_busy(b_rs_busy), .rd_i(b_rd_i), .rd(b_rd),
        .busy(b_busy), .ld_overlap(b_ld_overlap)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    logic [15:0] m_regs [16];
    logic [15:0] m_busy;
    logic        m_ovl;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_busy = 16'h0;
        m_ovl  = 1'b0;
    endtask

    // Value an ALU read port sees right now, bypass enabled.
    function automatic logic [15:0] m_read(input logic [3:0] idx);
        if (idx == 4'd0) return 16'h0;
        if (rd_i == idx) return rd;
        if (mem_load_en && mem_idx == idx) return mem_load;
        return m_regs[idx];
    endfunction

    function automatic logic m_rsbusy(input logic [3:0] idx);
        if (idx == 4'd0) return 1'b0;
        if (mem_load_en && mem_idx == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    // Edge update: memory write first, ALU write overrides; clear then set.
    task automatic m_update();
        m_ovl = ld_issue && (ld_idx != 4'd0) && m_busy[ld_idx] &&
                !(mem_load_en && mem_idx == ld_idx);
        if (mem_load_en) begin
            m_regs[mem_idx] = mem_load;
            m_busy[mem_idx] = 1'b0;
        end
        if (rd_i != 4'd0) m_regs[rd_i] = rd;
        if (ld_issue && ld_idx != 4'd0) m_busy[ld_idx] = 1'b1;
    endtask

    task automatic idle_a();
        mem_idx = 4'd0; mem_load = 16'h0; mem_load_en = 1'b0;
        ld_issue = 1'b0; ld_idx = 4'd0; rs_i = 8'h0; rd_i = 4'd0; rd = 16'h0;
    endtask

    task automatic idle_b();
        b_mem_idx = 4'd0; b_mem_load = 32'h0; b_mem_load_en = 1'b0;
        b_ld_issue = 1'b0; b_ld_idx = 4'd0; b_rs_i = 12'h0; b_rd_i = 4'd0; b_rd = 32'h0;
    endtask

    task automatic edge_a();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_idx     = 4'($urandom_range(0, 7));
            mem_load    = 16'($urandom);
            mem_load_en = ($urandom_range(0, 2) == 0);
            ld_issue    = ($urandom_range(0, 2) == 0);
            ld_idx      = 4'($urandom_range(0, 7));
            rs_i        = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            rd_i        = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 7)) : 4'd0;
            rd          = 16'($urandom);
            #2;
            chk("rand_rs0", rs[15:0], m_read(rs_i[3:0]));
            chk("rand_rs1", rs[31:16], m_read(rs_i[7:4]));
            chk("rand_rs_busy", rs_busy, {m_rsbusy(rs_i[7:4]), m_rsbusy(rs_i[3:0])});
            chk("rand_mem_store", mem_store, m_regs[mem_idx]);
            edge_a();
            chk("rand_busy", busy, m_busy);
            chk("rand_ld_overlap", ld_overlap, m_ovl);
        end
    endtask

    // ---------------- directed vector table for instance A ----------------
    typedef struct {
        logic [3:0]  mi;
        logic [15:0] ml;
        logic        mle;
        logic        li;
        logic [3:0]  lidx;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [3:0]  rdi;
        logic [15:0] rdv;
        logic [15:0] e_rs0;
        logic [15:0] e_rs1;
        logic [1:0]  e_rsb;
        logic [15:0] e_ms;
        logic [15:0] e_busy;
        logic        e_ovl;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           mi     ml        mle   li    lidx   r0     r1     rdi    rdv        rs0        rs1        rsb    ms         busy       ovl
        tbl[0]  = '{4'd5, 16'h1111, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, 4'd5, 16'h2222, 16'h2222, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{4'd5, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd5, 4'd5, 4'd0, 16'h0000, 16'h2222, 16'h2222, 2'b00, 16'h2222, 16'h0000, 1'b0};
        tbl[2]  = '{4'd0, 16'hABCD, 1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 4'd0, 16'hFFFF, 16'h0000, 16'h2222, 2'b00, 16'h0000, 16'h0000, 1'b0};
        tbl[3]  = '{4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'hFFFF, 16'h0000, 16'h0000, 2'b00, 16'hABCD, 16'h0000, 1'b0};
        tbl[4]  = '{4'd0, 16'h0000, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 16'hABCD, 16'h0008, 1'b0};
        tbl[5]  = '{4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd3, 4'd5, 4'd0, 16'h0000, 16'h0000, 16'h2222, 2'b01, 16'hABCD, 16'h0008, 1'b0};
        tbl[6]  = '{4'd3, 16'h00C3, 1'b1, 1'b0, 4'd0, 4'd3, 4'd3, 4'd0, 16'h0000, 16'h00C3, 16'h00C3, 2'b00, 16'h0000, 16'h0000, 1'b0};
        tbl[7]  = '{4'd3, 16'h0000, 1'b0, 1'b1, 4'd7, 4'd3, 4'd0, 4'd0, 16'h0000, 16'h00C3, 16'h0000, 2'b00, 16'h00C3, 16'h0080, 1'b0};
        tbl[8]  = '{4'd7, 16'h0077, 1'b1, 1'b1, 4'd7, 4'd7, 4'd7, 4'd0, 16'h0000, 16'h0077, 16'h0077, 2'b00, 16'h0000, 16'h0080, 1'b0};
        tbl[9]  = '{4'd7, 16'h0000, 1'b0, 1'b1, 4'd7, 4'd7, 4'd0, 4'd0, 16'h0000, 16'h0077, 16'h0000, 2'b01, 16'h0077, 16'h0080, 1'b1};
        tbl[10] = '{4'd7, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd7, 4'd7, 4'd0, 16'h0000, 16'h0077, 16'h0077, 2'b11, 16'h0077, 16'h0080, 1'b0};
        tbl[11] = '{4'd7, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd7, 16'h1234, 16'h1234, 16'h0000, 2'b01, 16'h0077, 16'h0080, 1'b0};
        tbl[12] = '{4'd7, 16'h0099, 1'b1, 1'b1, 4'd0, 4'd7, 4'd0, 4'd0, 16'h0000, 16'h0099, 16'h0000, 2'b00, 16'h1234, 16'h0000, 1'b0};
        tbl[13] = '{4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd0, 16'h0000, 16'h0099, 16'h0000, 2'b00, 16'hABCD, 16'h0000, 1'b0};

        idle_a();
        idle_b();
        rs_i   = 8'h21;
        b_rs_i = {4'd9, 4'd9, 4'd9};
        m_reset();

        // Reset state, held in reset
        #12;
        chk("reset_rs", rs, 32'h0);
        chk("reset_mem_store", mem_store, 16'h0);
        chk("reset_busy", busy, 16'h0);
        chk("reset_ld_overlap", ld_overlap, 1'b0);
        chk("reset_b_rs", b_rs, 96'h0);
        chk("reset_b_busy", b_busy, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table on instance A
        for (int v = 0; v < 14; v++) begin
            mem_idx = tbl[v].mi;  mem_load = tbl[v].ml;  mem_load_en = tbl[v].mle;
            ld_issue = tbl[v].li; ld_idx = tbl[v].lidx;
            rs_i = {tbl[v].r1, tbl[v].r0};
            rd_i = tbl[v].rdi;    rd = tbl[v].rdv;
            #2;
            chk($sformatf("vec%0d_rs0", v), rs[15:0], tbl[v].e_rs0);
            chk($sformatf("vec%0d_rs1", v), rs[31:16], tbl[v].e_rs1);
            chk($sformatf("vec%0d_rs_busy", v), rs_busy, tbl[v].e_rsb);
            chk($sformatf("vec%0d_mem_store", v), mem_store, tbl[v].e_ms);
            edge_a();
            chk($sformatf("vec%0d_busy", v), busy, tbl[v].e_busy);
            chk($sformatf("vec%0d_ld_overlap", v), ld_overlap, tbl[v].e_ovl);
        end
        idle_a();

        // Instance B: no bypass, 3 ports, 32-bit data
        b_rd_i = 4'd9; b_rd = 32'hDEADBEEF; b_mem_idx = 4'd9;
        #2;
        chk("b_same_cycle_old", b_rs, 96'h0);
        chk("b_store_old", b_mem_store, 32'h0);
        edge_a();
        b_rd_i = 4'd0;
        #2;
        chk("b_next_cycle_new", b_rs, {3{32'hDEADBEEF}});
        chk("b_store_new", b_mem_store, 32'hDEADBEEF);
        b_ld_issue = 1'b1; b_ld_idx = 4'd9;
        edge_a();
        chk("b_busy_set", b_busy, 16'h0200);
        b_ld_issue = 1'b0;
        b_mem_load_en = 1'b1; b_mem_load = 32'hCAFEF00D;
        #2;
        chk("b_rs_busy_no_bypass", b_rs_busy, 3'b111);
        chk("b_rs_no_bypass", b_rs, {3{32'hDEADBEEF}});
        edge_a();
        chk("b_busy_clear", b_busy, 16'h0000);
        b_mem_load_en = 1'b0;
        #2;
        chk("b_rs_loaded", b_rs, {3{32'hCAFEF00D}});
        chk("b_rs_busy_idle", b_rs_busy, 3'b000);
        edge_a();

        // Randomized traffic against the model
        rand_cycles(300);

        // Known non-zero state, then reset asserted mid-cycle
        idle_a();
        mem_idx = 4'd3; mem_load = 16'h5A5A; mem_load_en = 1'b1;
        ld_issue = 1'b1; ld_idx = 4'd5;
        edge_a();
        idle_a();
        mem_idx = 4'd3; rs_i = {4'd5, 4'd3};
        #2;
        chk("pre_reset_mem_store", mem_store, 16'h5A5A);
        chk("pre_reset_busy5", busy[5], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_rs", rs, 32'h0);
        chk("async_reset_mem_store", mem_store, 16'h0);
        chk("async_reset_busy", busy, 16'h0);
        chk("async_reset_ld_overlap", ld_overlap, 1'b0);
        chk("async_reset_b_rs", b_rs, 96'h0);
        chk("async_reset_b_store", b_mem_store, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
